pipe_stage_skid: RTL and testbench

- Parametrised two-entry skid-buffered pipeline stage register with valid/ready handshake and synchronous flush.
- Replaces the fixed-field, always-advancing stage registers between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Lets a wait-stated memory stall downstream without a combinational ready path upstream.
- The payload is an opaque vector; field packing is defined in the shared package.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_data_reg.sv | 19 +
 rtl/pipe_stage_skid.sv | 113 +++++++++++
 tb/tb_pipe_stage_skid.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: state encodings and MEM/WB payload layout.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int unsigned MEM_WB_W = 70;

  // MEM/WB bundle: {wb_en, mem_read, address[31:0], mem_out[31:0], dest[3:0]}
  localparam int unsigned MW_WB_EN      = 69;
  localparam int unsigned MW_MEM_READ   = 68;
  localparam int unsigned MW_ADDR_LSB   = 36;
  localparam int unsigned MW_MEMOUT_LSB = 4;
  localparam int unsigned MW_DEST_LSB   = 0;

endpackage

// File: rtl/pipe_data_reg.sv
// DATA_W-wide register with async reset, load enable and synchronous clear (clear wins over load).
module pipe_data_reg #(
  parameter int unsigned DATA_W = 70
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= '0;
    else if (clear) q <= '0;
    else if (load)  q <= d;
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline stage with registered in_ready and synchronous flush.
// Optional stall counter output enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W         = 70,
  parameter bit          CLEAR_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic              accept;
  logic              consume;
  logic              main_load;
  logic              skid_load;
  logic              clear;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_q;

  assign accept    = in_valid & in_ready;
  assign out_valid = (state != ST_EMPTY);
  assign consume   = out_valid & out_ready;
  assign clear     = flush & CLEAR_ON_FLUSH;
  // Only FULL refills main from the skid entry; every other main load takes fresh input.
  assign main_d    = (state == ST_FULL) ? skid_q : in_data;

  always_comb begin
    state_nx  = state;
    main_load = 1'b0;
    skid_load = 1'b0;
    if (flush) begin
      state_nx = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_nx  = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_nx  = ST_FULL;
          end else if (consume) begin
            state_nx  = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            main_load = 1'b1;
            state_nx  = ST_ONE;
          end
        end
        default: state_nx = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx != ST_FULL);
    end
  end

  pipe_data_reg #(.DATA_W(DATA_W)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (clear),
    .d     (main_d),
    .q     (out_data)
  );

  pipe_data_reg #(.DATA_W(DATA_W)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (clear),
    .d     (in_data),
    .q     (skid_q)
  );

`ifdef PIPE_STAGE_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid against a 2-deep queue reference model.
// Stall counter checks run when PIPE_STAGE_STALL_CNT_EN is defined.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int unsigned W = 70;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0]  stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] mq[$];

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(W), .CLEAR_ON_FLUSH(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  function automatic logic [W-1:0] rand_data();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  // Drive one cycle from a negedge; update the queue model at the posedge; return at next negedge.
  task automatic cyc(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    logic acc, con;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    acc = iv && (mq.size() < 2);
    con = ordy && (mq.size() > 0);
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (con) void'(mq.pop_front());
      if (acc) mq.push_back(d);
    end
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst = 1'b0;
    mq.delete();
    @(negedge clk);
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1, W'(k), 1'b1, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== W'(k) || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL stream_%0d got v=%b d=%h r=%b exp v=1 d=%h r=1", k, out_valid, out_data, in_ready, W'(k));
      end
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    cyc(1'b1, W'('hA), 1'b0, 1'b0);
    cyc(1'b1, W'('hB), 1'b0, 1'b0);
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== W'('hA)) begin
      n_err++; $display("FAIL bp_full got r=%b v=%b d=%h exp r=0 v=1 d=a", in_ready, out_valid, out_data);
    end
    cyc(1'b1, W'('hF), 1'b0, 1'b0);
    n_cmp++; if (out_data !== W'('hA)) begin n_err++; $display("FAIL bp_hold got=%h exp=a", out_data); end
    cyc(1'b0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== W'('hB) || in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_second got v=%b d=%h r=%b exp v=1 d=b r=1", out_valid, out_data, in_ready);
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    cyc(1'b1, W'(1), 1'b0, 1'b0);
    cyc(1'b1, W'(2), 1'b0, 1'b0);
    cyc(1'b1, W'('hC), 1'b0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_state got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    end
    n_cmp++;
    if (out_data !== '0 || dut.u_skid.q !== '0) begin
      n_err++; $display("FAIL flush_clear got main=%h skid=%h exp 0 0", out_data, dut.u_skid.q);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_emit got=%b exp=0", out_valid); end
    end
  endtask

  task automatic test_async_reset();
    cyc(1'b1, W'('h55), 1'b0, 1'b0);
    cyc(1'b1, W'('h66), 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL async_reset got v=%b d=%h r=%b exp v=0 d=0 r=1", out_valid, out_data, in_ready);
    end
    #1 rst = 1'b0;
    mq.delete();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_reset_after got=%b exp=0", out_valid); end
  endtask

  task automatic test_mem_wb();
    logic [W-1:0] p;
    p = rand_data();
    p[MW_WB_EN] = 1'b1;
    p[MW_ADDR_LSB +: 32] = 32'h100;
    p[MW_DEST_LSB +: 4]  = 4'hE;
    cyc(1'b1, p, 1'b0, 1'b0);
    n_cmp++;
    if (out_data[MW_WB_EN] !== 1'b1 || out_data[MW_ADDR_LSB +: 32] !== 32'h100 ||
        out_data[MW_DEST_LSB +: 4] !== 4'hE || out_data[MW_MEM_READ] !== p[MW_MEM_READ] ||
        out_data[MW_MEMOUT_LSB +: 32] !== p[MW_MEMOUT_LSB +: 32]) begin
      n_err++; $display("FAIL mem_wb_fields got=%h exp=%h", out_data, p);
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic iv, ordy, fl;
    for (int i = 0; i < 400; i++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 19) == 0);
      cyc(iv, rand_data(), ordy, fl);
      n_cmp++;
      if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) ||
          (mq.size() > 0 && out_data !== mq[0])) begin
        n_err++;
        $display("FAIL random_%0d got v=%b r=%b d=%h exp size=%0d front=%h", i, out_valid, in_ready,
                 out_data, mq.size(), (mq.size() > 0) ? mq[0] : '0);
      end
    end
    cyc(1'b0, '0, 1'b0, 1'b1);
  endtask

`ifdef PIPE_STAGE_STALL_CNT_EN
  task automatic test_stall_cnt();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    mq.delete();
    @(negedge clk);
    cyc(1'b1, W'(7), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if (stall_cnt !== 16'd5) begin n_err++; $display("FAIL stall_cnt5 got=%0d exp=5", stall_cnt); end
    cyc(1'b0, '0, 1'b1, 1'b1);
    n_cmp++; if (stall_cnt !== 16'd5) begin n_err++; $display("FAIL stall_flush got=%0d exp=5", stall_cnt); end
    cyc(1'b1, W'(8), 1'b0, 1'b0);
    repeat (65530) @(negedge clk);
    n_cmp++; if (stall_cnt !== 16'hFFFF) begin n_err++; $display("FAIL stall_sat got=%h exp=ffff", stall_cnt); end
    repeat (4) @(negedge clk);
    n_cmp++; if (stall_cnt !== 16'hFFFF) begin n_err++; $display("FAIL stall_stick got=%h exp=ffff", stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_mem_wb();
    test_random();
`ifdef PIPE_STAGE_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
